// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: instruction fetch front end for the MIPS datapath.
//
// Holds the PC, issues word fetches to instruction memory with one request
// outstanding at a time, and buffers returned instructions in a small FIFO.
// Instructions go to decode over a valid/ready handshake. A redirect loads a
// new PC, flushes the buffer and discards any response still in flight.
//
// Optional feature macro: FETCH_BYPASS_EN
//   Defined   : a response that arrives while the buffer is empty is presented
//               on id_* in the same cycle (combinational path from imem_rdata).
//               It is only written into the buffer if decode does not take it.
//   Undefined : id_* come from buffer registers only.
//
// Parameters
//   RESET_PC    : PC loaded at reset.
//   DEPTH       : instruction buffer entries (>= 1).
//
// Ports
//   clk         : clock, rising edge.
//   rst_n       : asynchronous active-low reset (memory side shares it).
//   imem_req    : fetch request valid.
//   imem_addr   : fetch word address, always the PC register.
//   imem_gnt    : request accepted when high together with imem_req.
//   imem_rvalid : response valid, earliest one cycle after grant.
//   imem_rdata  : response instruction word.
//   redirect    : pulse loading redirect_pc and flushing the stage.
//   redirect_pc : redirect target, bits [1:0] ignored.
//   id_valid    : instruction available to decode.
//   id_ready    : decode accepts the head instruction.
//   id_instr    : head instruction, zero when id_valid is low.
//   id_pc       : PC of the head instruction, zero when id_valid is low.
//   id_opcode   : id_instr[31:26], feeds the control decoder.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // Redirect from later stages
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  // Decode
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [5:0]  id_opcode
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

  if (DEPTH < 1) begin : g_depth_check
    $error("fetch_stage: DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StDrop  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic [31:0]     buf_instr_q [DEPTH];
  logic [31:0]     buf_pc_q    [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic resp_ok;   // response accepted into the pipe (WAIT, rvalid, no redirect)
  logic bypass;    // response presented directly on id_*
  logic buf_valid;
  logic push;
  logic pop;

  // Only the word-aligned part of the redirect target matters.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == LastPtr) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    imem_req = 1'b0;
    resp_ok  = 1'b0;

    unique case (state_q)
      StFetch: begin
        // rst_n gating keeps the request low for the whole reset period.
        imem_req = rst_n && (count_q < DepthCnt);
        // A grant coinciding with a redirect is treated as not accepted.
        if (!redirect && imem_req && imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          resp_ok = !redirect;
          state_d = StFetch;
        end else if (redirect) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_rvalid) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_addr = pc_q;

  // ---------------------------------------------------------------------------
  // Instruction buffer
  // ---------------------------------------------------------------------------
  assign buf_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_ok && !buf_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response taken by decode this cycle never enters the buffer.
  assign push = resp_ok && !(bypass && id_ready);
  // Redirect discards any pop in the same cycle.
  assign pop  = buf_valid && id_ready && !redirect;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    id_valid = buf_valid || bypass;
    id_instr = 32'h0000_0000;
    id_pc    = 32'h0000_0000;
    if (buf_valid) begin
      id_instr = buf_instr_q[rd_ptr_q];
      id_pc    = buf_pc_q[rd_ptr_q];
    end else if (bypass) begin
      id_instr = imem_rdata;
      id_pc    = req_pc_q;
    end
  end

  assign id_opcode = id_instr[31:26];

  // Responses are only legal while a request is outstanding.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !((state_q == StFetch) && imem_rvalid))
    else $error("fetch_stage: imem_rvalid with no outstanding request");

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef FETCH_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;

  int tests = 0;
  int fails = 0;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_opcode  (id_opcode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    next_cycle();
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_opcode", id_opcode, 6'h0);
    next_cycle();

    // C0: reset released, first request granted at PC 0
    rst_n = 1'b1; imem_gnt = 1'b1;
    #1;
    chk("c0_req", imem_req, 1);
    chk("c0_addr", imem_addr, 32'h0);
    next_cycle();
    // C1: response, decode stalled
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    #1;
    chk("c1_req", imem_req, 0);
    chk("c1_valid", id_valid, Bypass ? 1 : 0);
    chk("c1_instr", id_instr, Bypass ? 32'h2008_0005 : 32'h0);
    next_cycle();
    // C2: first instruction visible, second fetch at 4
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    #1;
    chk("c2_valid", id_valid, 1);
    chk("c2_pc", id_pc, 32'h0);
    chk("c2_opcode", id_opcode, 6'h08);
    chk("c2_instr", id_instr, 32'h2008_0005);
    chk("c2_req", imem_req, 1);
    chk("c2_addr", imem_addr, 32'h4);
    next_cycle();
    // C3: second response
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
    #1;
    chk("c3_stall_instr", id_instr, 32'h2008_0005);
    next_cycle();
    // C4/C5: buffer full, no requests
    imem_rvalid = 1'b0;
    #1;
    chk("c4_full_req", imem_req, 0);
    next_cycle();
    id_ready = 1'b1;
    #1;
    chk("c5_full_req", imem_req, 0);
    chk("c5_addr", imem_addr, 32'h8);
    chk("c5_pc", id_pc, 32'h0);
    next_cycle();
    // C6: second entry at head, fetching resumes at 8
    imem_gnt = 1'b1;
    #1;
    chk("c6_valid", id_valid, 1);
    chk("c6_pc", id_pc, 32'h4);
    chk("c6_instr", id_instr, 32'h8C01_0004);
    chk("c6_opcode", id_opcode, 6'h23);
    chk("c6_req", imem_req, 1);
    chk("c6_addr", imem_addr, 32'h8);
    next_cycle();
    // C7: buffer drained, redirect while waiting
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("c7_valid", id_valid, 0);
    chk("c7_instr", id_instr, 32'h0);
    chk("c7_pc", id_pc, 32'h0);
    next_cycle();
    // C8/C9: dropping the stale response
    redirect = 1'b0;
    #1;
    chk("c8_req", imem_req, 0);
    chk("c8_addr", imem_addr, 32'h0000_0100);
    next_cycle();
    #1;
    chk("c9_valid", id_valid, 0);
    next_cycle();
    // C10: stale response arrives 3 cycles after the redirect
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("c10_valid", id_valid, 0);
    chk("c10_req", imem_req, 0);
    next_cycle();
    // C11: fetch at redirect target
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    #1;
    chk("c11_valid", id_valid, 0);
    chk("c11_req", imem_req, 1);
    chk("c11_addr", imem_addr, 32'h0000_0100);
    next_cycle();
    // C12: redirect together with rvalid
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("c12_valid", id_valid, 0);
    next_cycle();
    // C13: fetch at target next cycle, nothing delivered
    redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
    #1;
    chk("c13_valid", id_valid, 0);
    chk("c13_req", imem_req, 1);
    chk("c13_addr", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    // C14: PC wrapped, response with decode ready
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0800_0040;
    #1;
    chk("c14_wrap_addr", imem_addr, 32'h0);
    chk("c14_req", imem_req, 0);
    chk("c14_valid", id_valid, Bypass ? 1 : 0);
    chk("c14_instr", id_instr, Bypass ? 32'h0800_0040 : 32'h0);
    next_cycle();
    // C15: redirect with a grant and a pop in the same cycle
    imem_rvalid = 1'b0; imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    chk("c15_valid", id_valid, Bypass ? 0 : 1);
    chk("c15_pc", id_pc, Bypass ? 32'h0 : 32'hFFFF_FFFC);
    chk("c15_opcode", id_opcode, Bypass ? 6'h00 : 6'h02);
    chk("c15_req", imem_req, 1);
    chk("c15_addr", imem_addr, 32'h0);
    next_cycle();
    // C16: grant ignored, fetch at new target
    redirect = 1'b0;
    #1;
    chk("c16_valid", id_valid, 0);
    chk("c16_req", imem_req, 1);
    chk("c16_addr", imem_addr, 32'h0000_0200);
    next_cycle();
    // C17: reset during an outstanding request
    imem_gnt = 1'b0;
    #1;
    chk("c17_addr", imem_addr, 32'h0000_0204);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", imem_req, 0);
    chk("midrst_addr", imem_addr, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk("postrst_req", imem_req, 1);
    chk("postrst_valid", id_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
